// File: rtl/nn_pkg.sv
// Shared neural-layer definitions: sign-magnitude width, sequencer states,
// and conversion / activation helpers reused by the layer blocks.
package nn_pkg;

    localparam int unsigned SM_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } nm_state_t;

    function automatic logic signed [SM_W-1:0] sm_to_signed(input logic [SM_W-1:0] sm);
        logic signed [SM_W-1:0] mag;
        mag = {1'b0, sm[SM_W-2:0]};
        return sm[SM_W-1] ? -mag : mag;
    endfunction

    // Callers sign-extend their accumulator to 64 bits before calling.
    function automatic logic [SM_W-1:0] relu_sat(input logic signed [63:0] r);
        if (r <= 64'sd0) begin
            return '0;
        end else if (r > 64'sd127) begin
            return 8'h7F;
        end else begin
            return {1'b0, r[SM_W-2:0]};
        end
    endfunction

endpackage

// File: rtl/sm_mult.sv
// Combinational 8x8 sign-magnitude multiplier producing a 15-bit
// two's-complement product; a -0 operand gives exactly 0.
module sm_mult
    import nn_pkg::*;
(
    input  logic [SM_W-1:0]          a_i,
    input  logic [SM_W-1:0]          b_i,
    output logic signed [2*SM_W-2:0] p_o
);

    logic [2*SM_W-3:0] mag;
    logic              neg;

    always_comb begin
        mag = a_i[SM_W-2:0] * b_i[SM_W-2:0];
        neg = a_i[SM_W-1] ^ b_i[SM_W-1];
        p_o = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron MAC sequencer: walks N weight/activation pairs, accumulates
// their products, then presents a ReLU-saturated result on valid/ready.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int unsigned N     = 10,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned SEL_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [SEL_W-1:0] w_sel,
    input  logic [7:0]       w_data,
    output logic [SEL_W-1:0] in_sel,
    input  logic [7:0]       in_data,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned     IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    if (N < 1 || N > 1024) begin : g_chk_n
        $error("neuron_mac: N out of range 1..1024");
    end
    if (ACC_W < 15 + $clog2(N) || ACC_W > 64) begin : g_chk_acc
        $error("neuron_mac: ACC_W must be >= 15+clog2(N) and <= 64");
    end

    nm_state_t               state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [SM_W-1:0]         out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    logic [SM_W-1:0]         w_op, x_op;
    logic signed [2*SM_W-2:0] prod;
    logic signed [ACC_W-1:0] acc_sum;

    // Operands are forced to zero outside ACCUM so unknown memory data never reaches acc.
    assign w_op = (state_q == ST_ACCUM) ? w_data  : '0;
    assign x_op = (state_q == ST_ACCUM) ? in_data : '0;

    sm_mult u_mult (
        .a_i (w_op),
        .b_i (x_op),
        .p_o (prod)
    );

    assign acc_sum = acc_q + ACC_W'(prod);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_sum;
                if (idx_q == IDX_LAST) begin
                    idx_d       = '0;
                    out_data_d  = relu_sat(64'(acc_sum));
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign w_sel     = (state_q == ST_ACCUM) ? SEL_W'(idx_q) : '0;
    assign in_sel    = w_sel;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized and directed bench for neuron_mac against an arithmetic
// reference that sums signed products over the weight/activation arrays.
module tb_neuron_mac;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst_n, start, out_ready;
    logic [31:0] w_sel, in_sel;
    logic [7:0]  w_data, in_data, out_data;
    logic        out_valid, busy;

    logic [7:0]  wmem [N];
    logic [7:0]  act  [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    neuron_mac #(.N(N), .ACC_W(24), .SEL_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .w_sel     (w_sel),
        .w_data    (w_data),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Weight memory and activation buffer answer combinationally; X when not addressed.
    assign w_data  = (busy && w_sel  < 32'(N)) ? wmem[w_sel[3:0]] : 8'hxx;
    assign in_data = (busy && in_sel < 32'(N)) ? act[in_sel[3:0]] : 8'hxx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int sm_val(input logic [7:0] v);
        return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
    endfunction

    function automatic logic [7:0] model_result();
        int s = 0;
        for (int i = 0; i < N; i++) s += sm_val(wmem[i]) * sm_val(act[i]);
        if (s <= 0) return 8'h00;
        if (s > 127) return 8'h7F;
        return 8'(s);
    endfunction

    task automatic std_weights();
        for (int i = 0; i < N; i++) wmem[i] = (i % 3 == 0) ? 8'h82 : 8'h04;
    endtask

    task automatic fill_act(input logic [7:0] v);
        for (int i = 0; i < N; i++) act[i] = v;
    endtask

    // Entered at a falling edge; leaves at the falling edge after the handshake.
    task automatic eval(input string tag, input int hold, input bit poke, input bit same_edge);
        logic [7:0] exp;
        int         cyc;
        int         q[$];
        exp   = model_result();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check({tag, "_busy_accum"}, 32'(busy), 1);
        while (!out_valid && cyc < N + 20) begin
            q.push_back(int'(w_sel));
            check({tag, "_insel"}, in_sel, w_sel);
            start = (poke && cyc == 4);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(N + 1));
        check({tag, "_nsel"}, 32'(q.size()), 32'(N));
        for (int i = 0; i < q.size() && i < N; i++) check({tag, "_wsel_seq"}, 32'(q[i]), 32'(i));
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        check({tag, "_busy_out"}, 32'(busy), 1);
        check({tag, "_wsel_out"}, w_sel, 0);
        for (int h = 0; h < hold; h++) begin
            start = (poke && h == 1);
            @(negedge clk);
            start = 1'b0;
            check({tag, "_hold_valid"}, 32'(out_valid), 1);
            check({tag, "_hold_data"}, 32'(out_data), 32'(exp));
        end
        out_ready = 1'b1;
        start     = same_edge;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 0);
        check({tag, "_busy_idle"}, 32'(busy), 0);
        if (same_edge) begin
            @(negedge clk);
            check({tag, "_no_restart"}, 32'(busy), 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        std_weights();
        fill_act(8'h01);
        #12;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wsel", w_sel, 0);
        check("rst_insel", in_sel, 0);
        check("rst_data", 32'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        eval("t1_ones", 0, 1'b0, 1'b0);
        check("t1_value", 32'(out_data), 32'h10);

        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        check("ready_idle_valid", 32'(out_valid), 0);
        check("ready_idle_busy", 32'(busy), 0);

        fill_act(8'h0A); @(negedge clk); eval("t2_sat", 0, 1'b0, 1'b0);
        check("t2_value", 32'(out_data), 32'h7F);
        fill_act(8'h81); @(negedge clk); eval("t2_neg", 0, 1'b0, 1'b0);
        fill_act(8'h80); @(negedge clk); eval("t3_negzero", 0, 1'b0, 1'b0);
        fill_act(8'h01); @(negedge clk); eval("t4_hold_poke", 5, 1'b1, 1'b0);
        fill_act(8'h0A); @(negedge clk); eval("t5_pre", 0, 1'b0, 1'b0);

        fill_act(8'h01);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 30 && w_sel != 32'd5; k++) @(negedge clk);
        check("t5_reach_idx5", w_sel, 5);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 0);
        check("t5_async_busy", 32'(busy), 0);
        check("t5_async_wsel", w_sel, 0);
        check("t5_async_data", 32'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        eval("t5_restart", 0, 1'b0, 1'b0);
        check("t5_value", 32'(out_data), 32'h10);

        @(negedge clk); eval("same_edge", 1, 1'b0, 1'b1);

        @(negedge clk); eval("b2b_a", 0, 1'b0, 1'b0);
        fill_act(8'h0A);
        eval("b2b_b", 0, 1'b0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++) begin
                wmem[i] = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 15))};
                act[i]  = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 15))};
            end
            @(negedge clk);
            eval("rand", $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
